// File: rtl/instr_fetch.sv
// RV32I fetch stage. It owns the PC, drives the instruction ROM address and
// registers the returned word, its PC and PC+4 into the IF/ID stage.
//
// state | meaning
// BOOT  | one settle cycle after reset; PC and IF/ID held, inputs ignored
// RUN   | normal fetch: redirect > misaligned halt > stall > capture
// HALT  | misaligned redirect seen; everything frozen until reset
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_rAddr,
  input  logic [31:0] instr_code,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        target_ok;

  assign target_ok = (redirect_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect && !target_ok) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Redirect wins over stall; a misaligned target freezes the PC for good.
  always_comb begin
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;
    if (state_q == RUN) begin
      if (redirect) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
        if (target_ok) pc_d = redirect_pc;
        else           misalign_d = 1'b1;
      end else if (!stall) begin
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_q + 32'd4;
        id_instr_d    = instr_code;
        id_valid_d    = 1'b1;
        pc_d          = pc_q + 32'd4;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_instr_q    <= NOP_INSTR;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instr_rAddr  = pc_q;
  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus4  = id_pc_plus4_q;
  assign id_instr     = id_instr_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table for the documented scenarios,
// then random stall/redirect/reset traffic against a reference model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] raddr, code, idpc, idp4, idins, cnt;
  logic        idv, mis;

  logic [31:0] w_raddr, w_code, w_idpc, w_idp4, w_idins, w_cnt;
  logic        w_idv, w_mis;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'd0;

  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hffff_0000 + (a >> 2);
  endfunction

  assign code   = rom(raddr);
  assign w_code = rom(w_raddr);

  instr_fetch dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_rAddr(raddr), .instr_code(code),
    .id_valid(idv), .id_pc(idpc), .id_pc_plus4(idp4), .id_instr(idins),
    .misalign_err(mis), .fetch_count(cnt));

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .stall(w_zero), .redirect(w_zero),
    .redirect_pc(w_zero32), .instr_rAddr(w_raddr), .instr_code(w_code),
    .id_valid(w_idv), .id_pc(w_idpc), .id_pc_plus4(w_idp4), .id_instr(w_idins),
    .misalign_err(w_mis), .fetch_count(w_cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        st, rd;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, ep4, eins, eaddr, ecnt;
    logic        emis;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ep4,
                              input logic [31:0] eins, input logic [31:0] eaddr,
                              input logic [31:0] ecnt, input logic emis);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.ev = ev; v.epc = epc; v.ep4 = ep4;
    v.eins = eins; v.eaddr = eaddr; v.ecnt = ecnt; v.emis = emis;
    return v;
  endfunction

  // Reference model: spec rules applied per clock edge.
  logic        m_boot, m_halt, m_valid, m_mis;
  logic [31:0] m_pc, m_idpc, m_p4, m_ins, m_cnt;

  task automatic model_reset();
    m_boot = 1; m_halt = 0; m_valid = 0; m_mis = 0;
    m_pc = 32'd0; m_idpc = 0; m_p4 = 0; m_ins = NOP; m_cnt = 0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc);
    if (m_halt) return;
    if (m_boot) begin m_boot = 0; return; end
    if (rd) begin
      m_valid = 0; m_ins = NOP;
      if (rpc % 4 == 0) m_pc = rpc;
      else begin m_mis = 1; m_halt = 1; end
    end else if (!st) begin
      m_idpc = m_pc; m_p4 = m_pc + 4; m_ins = rom(m_pc); m_valid = 1;
      m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_model();
    check("rnd_valid", {31'd0, idv}, {31'd0, m_valid});
    check("rnd_raddr", raddr, m_pc);
    check("rnd_id_pc", idpc, m_idpc);
    check("rnd_plus4", idp4, m_p4);
    check("rnd_instr", idins, m_ins);
    check("rnd_count", cnt, m_cnt);
    check("rnd_misalign", {31'd0, mis}, {31'd0, m_mis});
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(1, 1, 32'h40, 0, 32'h0,  32'h0,  NOP,          32'h0,  0, 0);
    vecs[1]  = mk(0, 0, 32'h0,  1, 32'h0,  32'h4,  32'hffff0000, 32'h4,  1, 0);
    vecs[2]  = mk(0, 0, 32'h0,  1, 32'h4,  32'h8,  32'hffff0001, 32'h8,  2, 0);
    vecs[3]  = mk(0, 0, 32'h0,  1, 32'h8,  32'hC,  32'hffff0002, 32'hC,  3, 0);
    vecs[4]  = mk(1, 0, 32'h0,  1, 32'h8,  32'hC,  32'hffff0002, 32'hC,  3, 0);
    vecs[5]  = mk(1, 0, 32'h0,  1, 32'h8,  32'hC,  32'hffff0002, 32'hC,  3, 0);
    vecs[6]  = mk(0, 0, 32'h0,  1, 32'hC,  32'h10, 32'hffff0003, 32'h10, 4, 0);
    vecs[7]  = mk(1, 1, 32'h20, 0, 32'hC,  32'h10, NOP,          32'h20, 4, 0);
    vecs[8]  = mk(0, 0, 32'h0,  1, 32'h20, 32'h24, 32'hffff0008, 32'h24, 5, 0);
    vecs[9]  = mk(0, 1, 32'h22, 0, 32'h20, 32'h24, NOP,          32'h24, 5, 1);
    vecs[10] = mk(0, 1, 32'h40, 0, 32'h20, 32'h24, NOP,          32'h24, 5, 1);
    vecs[11] = mk(0, 0, 32'h0,  0, 32'h20, 32'h24, NOP,          32'h24, 5, 1);

    #12;
    check("reset_valid", {31'd0, idv}, 32'd0);
    check("reset_raddr", raddr, 32'd0);
    check("reset_instr", idins, NOP);
    check("reset_count", cnt, 32'd0);
    check("reset_wrap_raddr", w_raddr, 32'hFFFF_FFFC);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].st; redirect = vecs[i].rd; redirect_pc = vecs[i].rpc;
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), {31'd0, idv}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_id_pc", i), idpc, vecs[i].epc);
      check($sformatf("v%0d_plus4", i), idp4, vecs[i].ep4);
      check($sformatf("v%0d_instr", i), idins, vecs[i].eins);
      check($sformatf("v%0d_raddr", i), raddr, vecs[i].eaddr);
      check($sformatf("v%0d_count", i), cnt, vecs[i].ecnt);
      check($sformatf("v%0d_misalign", i), {31'd0, mis}, {31'd0, vecs[i].emis});
      if (i == 1) begin
        check("wrap_id_pc0", w_idpc, 32'hFFFF_FFFC);
        check("wrap_plus4_0", w_idp4, 32'h0);
        check("wrap_instr0", w_idins, 32'hffff0000 + 32'h3FFF_FFFF);
      end
      if (i == 2) begin
        check("wrap_id_pc1", w_idpc, 32'h0);
        check("wrap_plus4_1", w_idp4, 32'h4);
      end
    end
    stall = 0; redirect = 0;

    // Reset pulse out of HALT, asserted between edges.
    #2 reset_n = 1'b0;
    #1;
    check("halt_rst_misalign", {31'd0, mis}, 32'd0);
    check("halt_rst_raddr", raddr, 32'd0);
    #1 reset_n = 1'b1;
    model_reset();

    for (int c = 0; c < 800; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 15) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      model_edge(stall, redirect, redirect_pc);
      @(posedge clk); #1;
      check_model();
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_valid", {31'd0, idv}, 32'd0);
        check("async_raddr", raddr, 32'd0);
        check("async_count", cnt, 32'd0);
        check("async_misalign", {31'd0, mis}, 32'd0);
        #1 reset_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
